// File: rtl/mips_boot_loader.sv
// Loads a MIPS program from a byte stream (16-bit word count, then big-endian words) into instruction memory.
// Latency: one imem write the cycle after a word's 4th byte is accepted; peak rate one word per 5 cycles.
// Backpressure: in_ready is registered and high only while a header or word byte is being awaited.
module mips_boot_loader #(
    parameter int ADDR_W   = 8,
    parameter int RST_HOLD = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    localparam int DEPTH = 1 << ADDR_W;
    // One extra bit so the word index can reach DEPTH when a full memory image is loaded.
    localparam int WI_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_HI  = 3'd1,
        HDR_LO  = 3'd2,
        WORD    = 3'd3,
        WRITE   = 3'd4,
        RELEASE = 3'd5,
        DONE    = 3'd6,
        ERR     = 3'd7
    } state_t;

    state_t state, state_nxt;

    logic [15:0]     count_q;
    logic [WI_W-1:0] word_idx;
    logic [1:0]      byte_idx;
    logic [31:0]     asm_q;
    logic [15:0]     rel_cnt;
    logic            in_ready_q;

    logic        accept;
    logic [15:0] hdr;
    logic        hdr_bad;
    logic [15:0] word_inc16;
    logic        last_word;

    assign accept     = in_valid && in_ready_q;
    assign hdr        = {count_q[15:8], in_data};
    assign hdr_bad    = (hdr == 16'd0) || ({16'd0, hdr} > 32'(DEPTH));
    assign word_inc16 = 16'(word_idx) + 16'd1;
    assign last_word  = (word_inc16 == count_q);

    // State register; reset drops straight back to IDLE, discarding any load in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; start is only honoured in IDLE, DONE and ERR.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = HDR_HI;
            HDR_HI:  if (accept) state_nxt = HDR_LO;
            HDR_LO:  if (accept) state_nxt = hdr_bad ? ERR : WORD;
            WORD:    if (accept && byte_idx == 2'd3) state_nxt = WRITE;
            WRITE: begin
                if (!last_word)        state_nxt = WORD;
                else if (RST_HOLD > 0) state_nxt = RELEASE;
                else                   state_nxt = DONE;
            end
            RELEASE: if (rel_cnt == 16'(RST_HOLD - 1)) state_nxt = DONE;
            DONE:    if (start) state_nxt = HDR_HI;
            ERR:     if (start) state_nxt = HDR_HI;
            default: state_nxt = IDLE;
        endcase
    end

    // Header capture, word assembly, index counters, reset-hold timer and registered in_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            asm_q      <= '0;
            rel_cnt    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (state_nxt == HDR_HI) || (state_nxt == HDR_LO) || (state_nxt == WORD);
            case (state)
                HDR_HI: begin
                    if (accept) count_q[15:8] <= in_data;
                end
                HDR_LO: begin
                    if (accept) begin
                        count_q[7:0] <= in_data;
                        word_idx     <= '0;
                        byte_idx     <= '0;
                    end
                end
                WORD: begin
                    if (accept) begin
                        asm_q    <= {asm_q[23:0], in_data};
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + WI_W'(1);
                    byte_idx <= '0;
                    rel_cnt  <= '0;
                end
                RELEASE: begin
                    rel_cnt <= rel_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = (state == WRITE);
    assign imem_addr  = word_idx[ADDR_W-1:0];
    assign imem_wdata = asm_q;
    assign core_reset = (state != DONE);
    assign done       = (state == DONE);
    assign error      = (state == ERR);

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench for mips_boot_loader: expected imem writes go to a scoreboard queue,
// a negedge monitor pops and compares on every imem_we; status outputs are checked inline.
// Stimulus drives on negedge so inputs are stable across each rising edge.
module tb_mips_boot_loader;

    localparam int ADDR_W   = 8;
    localparam int RST_HOLD = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;

    int n_vec  = 0;
    int n_fail = 0;

    logic [39:0] exp_q[$];   // {addr, data}

    mips_boot_loader #(.ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every imem_we must match the next queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && imem_we === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected at %0t",
                         imem_addr, imem_wdata, $time);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr 0x%0h data 0x%08h expected addr 0x%0h data 0x%08h",
                             imem_addr, imem_wdata, e[39:32], e[31:0]);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 60; i++) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL byte_timeout: in_ready 0 expected 1 for byte 0x%02h", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Standard two-word load, called at a negedge with the DUT in IDLE/DONE/ERR.
    task automatic two_word_load(input int gap);
        logic [7:0] w [8];
        w = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
        pulse_start();
        chk("start_in_ready", {31'd0, in_ready}, 32'd1);
        chk("start_core_reset", {31'd0, core_reset}, 32'd1);
        send_byte(8'h00, gap);
        send_byte(8'h02, gap);
        exp_q.push_back({8'h00, 32'h2008_0005});
        for (int k = 0; k < 4; k++) send_byte(w[k], gap);
        chk("w0_latency_we", {31'd0, imem_we}, 32'd1);
        chk("w0_write_in_ready", {31'd0, in_ready}, 32'd0);
        exp_q.push_back({8'h01, 32'h2009_0007});
        for (int k = 4; k < 8; k++) send_byte(w[k], gap);
        chk("w1_latency_we", {31'd0, imem_we}, 32'd1);
        @(negedge clk);
        chk("release1_core_reset", {31'd0, core_reset}, 32'd1);
        chk("release1_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("release2_core_reset", {31'd0, core_reset}, 32'd1);
        @(negedge clk);
        chk("done_core_reset", {31'd0, core_reset}, 32'd0);
        chk("done_flag", {31'd0, done}, 32'd1);
        chk("done_error", {31'd0, error}, 32'd0);
        chk("writes_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_addr_data", {24'd0, imem_addr} | imem_wdata, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_wait_in_ready", {31'd0, in_ready}, 32'd0);

        // Two-word load, no gaps
        two_word_load(0);

        // Bytes after the last word are refused
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_load_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;

        // Zero header
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("zero_hdr_error", {31'd0, error}, 32'd1);
        chk("zero_hdr_core_reset", {31'd0, core_reset}, 32'd1);
        chk("zero_hdr_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("err_sticky", {31'd0, error}, 32'd1);
        pulse_start();
        chk("err_cleared", {31'd0, error}, 32'd0);
        chk("err_restart_in_ready", {31'd0, in_ready}, 32'd1);

        // Oversize header (already in HDR_HI): 0x0101 = 257 > 256
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk("oversize_error", {31'd0, error}, 32'd1);
        chk("oversize_core_reset", {31'd0, core_reset}, 32'd1);

        // Stalled stream from ERR: 3 idle cycles before every byte
        two_word_load(3);

        // Reset mid-word: header plus two bytes of word 0, then reset
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_core_reset", {31'd0, core_reset}, 32'd1);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_wdata", imem_wdata, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_idle_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_idle_done", {31'd0, done}, 32'd0);

        // Reload after reset, then restart from DONE
        two_word_load(0);
        pulse_start();
        chk("reload_core_reset", {31'd0, core_reset}, 32'd1);
        chk("reload_done", {31'd0, done}, 32'd0);
        chk("reload_in_ready", {31'd0, in_ready}, 32'd1);

        repeat (3) @(negedge clk);
        chk("final_no_pending", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/mips_boot_loader.md
MIPS_BOOT_LOADER -- requirements
Module: mips_boot_loader

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2^ADDR_W.
- RST_HOLD, 2, cycles core_reset stays asserted after the last write.

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a program load.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte-stream ready, registered.
- imem_we  out  1  instruction-memory write enable, one cycle per word.
- imem_addr  out  ADDR_W  word address; byte address = imem_addr*4.
- imem_wdata  out  32  instruction word.
- core_reset  out  1  active-high reset to the MIPS core.
- done  out  1  load complete, core running.
- error  out  1  bad header detected.

REQ-003 A byte SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1; in_valid gaps SHALL stall the block with no side effects.

Function
REQ-004 Stream format SHALL be a 2-byte big-endian word count N, then N words of 4 bytes each, big-endian (first byte = bits 31:24).

REQ-005 States SHALL be IDLE, HDR_HI, HDR_LO, WORD, WRITE, RELEASE, DONE, ERR.

REQ-006 IDLE SHALL behave as follows:
- core_reset=1, in_ready=0.
- start=1 -> HDR_HI.

REQ-007 HDR_HI SHALL accept one byte into count[15:8] -> HDR_LO.

REQ-008 HDR_LO SHALL accept one byte into count[7:0]:
- count=0 or count>DEPTH -> ERR.
- Otherwise -> WORD, with word index=0 and byte index=0.

REQ-009 WORD SHALL shift accepted bytes into a 32-bit assembly register (shift left 8, insert at [7:0]); acceptance of the 4th byte -> WRITE.

REQ-010 WRITE SHALL last exactly one cycle:
- Outputs: imem_we=1, imem_addr=word index, imem_wdata=assembled word, in_ready=0.
- Word index then increments.
- If the incremented index equals count -> RELEASE; else -> WORD with byte index=0.

REQ-011 in_ready SHALL be 1 only in HDR_HI, HDR_LO and WORD, and SHALL be 0 in all other states.

REQ-012 Byte-to-write latency SHALL be: imem_we asserts in the cycle immediately after the edge accepting a word's 4th byte; peak throughput is one word per 5 cycles.

REQ-013 RELEASE SHALL keep core_reset=1 for exactly RST_HOLD cycles, then -> DONE.

REQ-014 DONE SHALL drive core_reset=0 and done=1; start=1 -> HDR_HI, with core_reset=1 and done=0 from the next cycle (reload).

REQ-015 ERR SHALL behave as follows:
- error=1, core_reset=1, in_ready=0, no writes.
- Only start=1 leaves ERR -> HDR_HI, with error cleared.

REQ-016 start SHALL be ignored in HDR_HI, HDR_LO, WORD, WRITE and RELEASE.

REQ-017 core_reset SHALL be 1 in every state except DONE.

REQ-018 imem_we SHALL never assert outside WRITE, and the number of writes per load SHALL equal count exactly.

REQ-019 Bytes presented after the last word SHALL NOT be accepted (in_ready=0).

Reset
REQ-020 While reset=0, the block SHALL immediately (asynchronously) enter IDLE with this state:
- core_reset=1.
- in_ready=0, imem_we=0, done=0, error=0.
- imem_addr=0, imem_wdata=0.
- count, word index, byte index and assembly register all 0.

REQ-021 Reset assertion mid-load SHALL abort the load with no further writes; a partially assembled word SHALL be discarded.

REQ-022 After reset=1, the block SHALL remain in IDLE until start.

Verification
REQ-023 Reset check: reset=0 for 2 cycles -> core_reset=1, in_ready=0, imem_we=0, done=0, error=0.

REQ-024 Two-word load: start, then bytes 00 02 20 08 00 05 20 09 00 07 ->
- imem_we pulses twice: addr 0 with data 0x20080005, then addr 1 with data 0x20090007.
- core_reset falls RST_HOLD=2 cycles after the second write; done=1.

REQ-025 Zero header: start, then bytes 00 00 -> error=1, no imem_we, core_reset stays 1; a following start clears error.

REQ-026 Oversize header: ADDR_W=8, start, then bytes 01 01 (257>256) -> error=1, no writes.

REQ-027 Stalled stream: the REQ-024 bytes with in_valid=0 for 3 cycles between every byte -> identical writes and data, no extra imem_we, done=1.

REQ-028 Reset mid-word plus reload: assert reset after byte 2 of word 0 -> IDLE with no write; then start plus the REQ-024 stream -> correct two writes, done=1; then start in DONE -> core_reset=1 and done=0 on the next cycle.
